// File: rtl/time_base_mm_ss.sv
// mm:ss BCD timebase: prescaler to a one-second tick, seconds/minutes counters, validated time-set load.
// Min/Sec/Load_Err update one edge after tick or load; Sec_Tick/Hour_Enable are same-cycle; no backpressure.
module time_base_mm_ss #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       Load,
    input  logic [7:0] Load_Min,
    input  logic [7:0] Load_Sec,
    output logic [7:0] Min,
    output logic [7:0] Sec,
    output logic       Sec_Tick,
    output logic       Hour_Enable,
    output logic       Load_Err
);

    localparam logic [15:0] PRESC_MAX = 16'(CLK_DIV - 1);

    logic [15:0] presc_q, presc_d;
    logic [7:0]  sec_q, sec_d;
    logic [7:0]  min_q, min_d;
    logic        load_err_q, load_err_d;

    logic        tick;
    logic        sec_wrap;
    logic        load_ok;

    function automatic logic bcd_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    // Advance a 00..59 BCD value by one, wrapping 59 back to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h59) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {4'(v[7:4] + 4'd1), 4'd0};
        end else begin
            r = {v[7:4], 4'(v[3:0] + 4'd1)};
        end
        return r;
    endfunction

    always_comb begin
        tick     = ~Reset & Enable & ~Load & (presc_q == PRESC_MAX);
        sec_wrap = (sec_q == 8'h59);
        load_ok  = bcd_valid(Load_Min) & bcd_valid(Load_Sec);

        presc_d    = presc_q;
        sec_d      = sec_q;
        min_d      = min_q;
        load_err_d = 1'b0;

        if (Load) begin
            // A rejected load leaves all counting state untouched.
            if (load_ok) begin
                presc_d = 16'd0;
                sec_d   = Load_Sec;
                min_d   = Load_Min;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (Enable) begin
            presc_d = (presc_q == PRESC_MAX) ? 16'd0 : 16'(presc_q + 16'd1);
            if (tick) begin
                sec_d = bcd_inc(sec_q);
                if (sec_wrap) begin
                    min_d = bcd_inc(min_q);
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            presc_q    <= 16'd0;
            sec_q      <= 8'h00;
            min_q      <= 8'h00;
            load_err_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            load_err_q <= load_err_d;
        end
    end

    assign Min         = min_q;
    assign Sec         = sec_q;
    assign Load_Err    = load_err_q;
    assign Sec_Tick    = tick;
    assign Hour_Enable = tick & sec_wrap & (min_q == 8'h59);

endmodule

// File: tb/tb_time_base_mm_ss.sv
// Bench for time_base_mm_ss: directed plan steps plus random run, checked against an elapsed-seconds model.
module tb_time_base_mm_ss;

    localparam int CLK_DIV = 4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Enable;
    logic       Load;
    logic [7:0] Load_Min;
    logic [7:0] Load_Sec;
    logic [7:0] Min;
    logic [7:0] Sec;
    logic       Sec_Tick;
    logic       Hour_Enable;
    logic       Load_Err;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Model: time as total seconds past 00:00, prescaler as a plain count.
    int m_total;
    int m_presc;
    int m_err;

    time_base_mm_ss #(.CLK_DIV(CLK_DIV)) dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .Load(Load),
        .Load_Min(Load_Min), .Load_Sec(Load_Sec),
        .Min(Min), .Sec(Sec), .Sec_Tick(Sec_Tick),
        .Hour_Enable(Hour_Enable), .Load_Err(Load_Err)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] to_bcd(input int n);
        return 8'(((n / 10) * 16) + (n % 10));
    endfunction

    function automatic bit bcd_ok(input int v);
        return ((v % 16) <= 9) && ((v / 16) <= 5);
    endfunction

    function automatic int bcd_val(input int v);
        return (v / 16) * 10 + (v % 16);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_total = 0;
        m_presc = 0;
        m_err   = 0;
    endtask

    task automatic step(input logic en, input logic ld, input logic [7:0] lm, input logic [7:0] ls);
        bit tick;
        bit hour;
        Enable = en; Load = ld; Load_Min = lm; Load_Sec = ls;
        @(negedge Clk);
        tick = en && !ld && (m_presc == CLK_DIV - 1);
        hour = tick && (m_total == 3599);
        chk("sec_tick", {7'd0, Sec_Tick}, {7'd0, tick});
        chk("hour_enable", {7'd0, Hour_Enable}, {7'd0, hour});
        @(posedge Clk);
        if (ld) begin
            if (bcd_ok(int'(lm)) && bcd_ok(int'(ls))) begin
                m_total = bcd_val(int'(lm)) * 60 + bcd_val(int'(ls));
                m_presc = 0;
                m_err   = 0;
            end else begin
                m_err = 1;
            end
        end else begin
            m_err = 0;
            if (en) begin
                m_presc = (m_presc + 1) % CLK_DIV;
                if (tick) m_total = (m_total + 1) % 3600;
            end
        end
        #1;
        chk("min", Min, to_bcd(m_total / 60));
        chk("sec", Sec, to_bcd(m_total % 60));
        chk("load_err", {7'd0, Load_Err}, 8'(m_err));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        Reset = 1'b1; Enable = 1'b1; Load = 1'b0; Load_Min = 8'h00; Load_Sec = 8'h00;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_min", Min, 8'h00);
        chk("rst_sec", Sec, 8'h00);
        chk("rst_tick", {7'd0, Sec_Tick}, 8'h00);
        chk("rst_err", {7'd0, Load_Err}, 8'h00);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        // The edge right after release counts as the first enabled cycle.
        m_presc = 1;

        // Count 00 -> 04 with a tick every fourth cycle.
        run(15);
        chk("plan1_sec", Sec, 8'h04);

        // 12:58 across the minute boundary.
        step(1'b1, 1'b1, 8'h12, 8'h58);
        run(8);
        chk("plan2_min", Min, 8'h13);

        // 59:59 wrap raises Hour_Enable once.
        step(1'b1, 1'b1, 8'h59, 8'h59);
        run(5);
        chk("plan3_sec", Sec, 8'h00);

        // Invalid load while counting at 07.
        step(1'b1, 1'b1, 8'h00, 8'h07);
        run(2);
        step(1'b1, 1'b1, 8'h30, 8'h6A);
        run(6);

        // Load collides with the tick at 59:59.
        step(1'b1, 1'b1, 8'h59, 8'h59);
        run(3);
        step(1'b1, 1'b1, 8'h05, 8'h05);
        chk("plan5_min", Min, 8'h05);
        run(5);

        // Invalid load held, then made valid, and load with Enable low.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h7A, 8'h10);
        step(1'b0, 1'b1, 8'h45, 8'h30);
        run(4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic       en;
            logic       ld;
            logic [7:0] lm;
            logic [7:0] ls;
            en = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) != 0) begin
                lm = to_bcd(int'($urandom_range(0, 59)));
                ls = to_bcd(int'($urandom_range(0, 59)));
            end else begin
                lm = 8'($urandom);
                ls = 8'($urandom);
            end
            step(en, ld, lm, ls);
        end

        // Freeze, then asynchronous reset between edges.
        step(1'b1, 1'b1, 8'h21, 8'h33);
        run(2);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 8'h00);
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        chk("async_min", Min, 8'h00);
        chk("async_sec", Sec, 8'h00);
        chk("async_err", {7'd0, Load_Err}, 8'h00);
        chk("async_tick", {7'd0, Sec_Tick}, 8'h00);
        chk("async_hour", {7'd0, Hour_Enable}, 8'h00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
